uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter that answers the single-cycle core's data-memory port: it decodes store/load accesses inside its address window, buffers store bytes in a FIFO, and serialises them 8N1 (optionally 8E1) on `txd`. Reads are combinational so the core's single-cycle load path sees correctly sign/zero-extended data in the same cycle. Sits beside data RAM; the SoC read mux selects `rdata` when `hit` is high.

---
 rtl/uart_tx_pkg.sv | 35 +++
 rtl/uart_tx_if.sv | 20 ++
 rtl/uart_tx_mmio_fifo.sv | 51 +++++
 rtl/uart_tx_mmio.sv | 208 ++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS bit indices, bus encodings, FSM states.
package uart_tx_pkg;

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_BAUDDIV = 2'd2;
  localparam logic [1:0] OFF_RSVD    = 2'd3;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 8;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_SB   = 2'b01;
  localparam logic [1:0] MW_SH   = 2'b10;
  localparam logic [1:0] MW_SW   = 2'b11;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Data-memory port between the core and the UART register window.
// Core drives address/data/strobes; the UART returns hit and load data.
interface uart_tx_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  mem_write;
  logic [2:0]  size_load;
  logic [31:0] rdata;
  logic        hit;

  modport master (
    output addr, wdata, mem_write, size_load,
    input  rdata, hit
  );

  modport slave (
    input  addr, wdata, mem_write, size_load,
    output rdata, hit
  );
endinterface

// File: rtl/uart_tx_mmio_fifo.sv
// sync_fifo: single-clock FIFO; pushes when full and pops when
// empty are ignored, so callers may strobe without pre-checking.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter, 8N1 by default; define
// UART_TX_PARITY_EN for 8E1 (even parity bit after data bit 7).
module uart_tx_mmio
  import uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus,
  output logic     txd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] rel;
  logic [1:0]  off;
  logic        wr;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [7:0]  fdout;
  logic [CW-1:0] fcount;

  logic        ovf;
  logic [15:0] div;
  logic [15:0] divm;

  tx_state_e   state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  data, data_n;
  logic        par, par_n;
  logic        txd_n;
  logic        last;

  assign rel      = bus.addr - BASE_ADDR;
  assign off      = rel[3:2];
  assign bus.hit  = (rel[31:4] == '0);
  assign wr       = bus.hit && (bus.mem_write != MW_NONE);
  assign push     = wr && (off == OFF_TXDATA);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.wdata[7:0]),
    .dout  (fdout),
    .full  (full),
    .empty (empty),
    .count (fcount)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
      div <= DEFAULT_DIV;
    end else begin
      if (push && full)
        ovf <= 1'b1;
      else if (wr && off == OFF_STATUS && bus.wdata[3])
        ovf <= 1'b0;
      if (wr && off == OFF_BAUDDIV)
        div <= bus.wdata[15:0];
    end
  end

  // A divisor of 0 behaves as 1 so the line can never stall.
  assign divm = (div == '0) ? 16'd1 : div;
  assign last = (cnt <= 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      data  <= '0;
      par   <= 1'b0;
      txd   <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      data  <= data_n;
      par   <= par_n;
      txd   <= txd_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = last ? cnt : cnt - 1'b1;
    idx_n   = idx;
    data_n  = data;
    par_n   = par;
    txd_n   = txd;
    pop     = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_n = cnt;
        if (!empty) begin
          pop     = 1'b1;
          state_n = S_START;
          data_n  = fdout;
          par_n   = ^fdout;
          cnt_n   = divm;
          txd_n   = 1'b0;
        end
      end
      S_START: begin
        if (last) begin
          state_n = S_DATA;
          idx_n   = '0;
          cnt_n   = divm;
          txd_n   = data[0];
        end
      end
      S_DATA: begin
        if (last) begin
          cnt_n = divm;
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = S_PARITY;
            txd_n   = par;
`else
            state_n = S_STOP;
            txd_n   = 1'b1;
`endif
          end else begin
            idx_n  = idx + 1'b1;
            data_n = {1'b0, data[7:1]};
            txd_n  = data[1];
          end
        end
      end
      S_PARITY: begin
        if (last) begin
          state_n = S_STOP;
          cnt_n   = divm;
          txd_n   = 1'b1;
        end
      end
      S_STOP: begin
        if (last) begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = S_START;
            data_n  = fdout;
            par_n   = ^fdout;
            cnt_n   = divm;
            txd_n   = 1'b0;
          end else begin
            state_n = S_IDLE;
            txd_n   = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

  logic [31:0] status;
  logic [31:0] word;
  logic [31:0] bsh;
  logic [31:0] hsh;

  always_comb begin
    status = '0;
    status[ST_BUSY]  = (state != S_IDLE);
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[ST_OVF]   = ovf;
    status[ST_CNT+:4] = 4'(fcount);
  end

  always_comb begin
    word = '0;
    unique case (1'b1)
      (off == OFF_STATUS):  word = status;
      (off == OFF_BAUDDIV): word = {16'h0, div};
      default:              word = '0;
    endcase
  end

  assign bsh = word >> {rel[1:0], 3'b000};
  assign hsh = word >> {rel[1], 4'b0000};

  always_comb begin
    bus.rdata = '0;
    if (bus.hit) begin
      unique case (bus.size_load)
        LD_LB:   bus.rdata = {{24{bsh[7]}}, bsh[7:0]};
        LD_LH:   bus.rdata = {{16{hsh[15]}}, hsh[15:0]};
        LD_LBU:  bus.rdata = {24'h0, bsh[7:0]};
        LD_LHU:  bus.rdata = {16'h0, hsh[15:0]};
        default: bus.rdata = word;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio; frame length
// follows UART_TX_PARITY_EN when that macro is defined.
module tb_uart_tx_mmio;

  localparam logic [31:0] B = 32'h0000_1000;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic reset;
  logic txd;
  int   npass = 0;
  int   ntot  = 0;

  uart_tx_if bus ();

  uart_tx_mmio dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] mw);
    @(negedge clk);
    bus.addr      = a;
    bus.wdata     = d;
    bus.mem_write = mw;
    @(posedge clk);
    #1;
    bus.mem_write = 2'b00;
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] sz,
                    output logic [31:0] d);
    bus.addr      = a;
    bus.size_load = sz;
    #1;
    d = bus.rdata;
  endtask

  // Expects the current sample to be the first cycle of the start bit.
  task automatic check_frame(input logic [7:0] b, input int dv);
    logic [NB-1:0] bits;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = b;
`ifdef UART_TX_PARITY_EN
    bits[9] = ^b;
`endif
    for (int i = 0; i < NB; i++) begin
      for (int c = 0; c < dv; c++) begin
        check($sformatf("txd b%0d c%0d", i, c), 32'(txd), 32'(bits[i]));
        @(posedge clk);
        #1;
      end
    end
  endtask

  logic [31:0] r;

  initial begin
    reset         = 1'b1;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.mem_write = 2'b00;
    bus.size_load = 3'b010;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("rst txd", 32'(txd), 32'd1);
    ld(B + 4, 3'b010, r);
    check("rst status", r, 32'h0000_0004);
    ld(B + 8, 3'b010, r);
    check("rst div", r, 32'd868);
    st(B + 8, 32'd4, 2'b11);
    ld(B + 8, 3'b010, r);
    check("div4", r, 32'd4);

    st(B + 0, 32'hAAAA_AA55, 2'b01);
    check("txd pre-pop", 32'(txd), 32'd1);
    ld(B + 4, 3'b010, r);
    check("status post-push", r, 32'h0000_0100);
    @(posedge clk);
    #1;
    check_frame(8'h55, 4);
    ld(B + 4, 3'b010, r);
    check("busy clear", r, 32'h0000_0004);

    st(B + 8, 32'd1000, 2'b11);
    st(B + 0, 32'h11, 2'b11);
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      st(B + 0, 32'(i), 2'b11);
      ld(B + 4, 3'b010, r);
      if (i == 7) check("full 8th", r, 32'h0000_0803);
    end
    check("ovf 9th", r, 32'h0000_080B);
    st(B + 4, 32'h8, 2'b11);
    ld(B + 4, 3'b010, r);
    check("ovf clr", r, 32'h0000_0803);

    check("midframe txd", 32'(txd), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("async rst txd", 32'(txd), 32'd1);
    ld(B + 4, 3'b010, r);
    check("async rst status", r, 32'h0000_0004);
    @(negedge clk);
    reset = 1'b0;

    st(B + 8, 32'h0000_00F0, 2'b11);
    ld(B + 8, 3'b000, r);
    check("lb", r, 32'hFFFF_FFF0);
    ld(B + 8, 3'b100, r);
    check("lbu", r, 32'h0000_00F0);
    ld(B + 10, 3'b101, r);
    check("lhu hi", r, 32'h0);
    ld(B + 8, 3'b001, r);
    check("lh", r, 32'h0000_00F0);
    ld(B + 4, 3'b100, r);
    check("lbu status", r, 32'h0000_0004);
    ld(B + 0, 3'b010, r);
    check("txdata rd", r, 32'h0);

    ld(B - 4, 3'b010, r);
    check("hit lo", 32'(bus.hit), 32'd0);
    check("rdata lo", r, 32'h0);
    ld(B + 16, 3'b010, r);
    check("hit hi", 32'(bus.hit), 32'd0);
    check("rdata hi", r, 32'h0);
    ld(B + 15, 3'b010, r);
    check("hit top", 32'(bus.hit), 32'd1);
    st(B + 16, 32'h77, 2'b11);
    st(B - 4, 32'h77, 2'b11);
    ld(B + 4, 3'b010, r);
    check("oow no push", r, 32'h0000_0004);
    check("oow txd", 32'(txd), 32'd1);

    st(B + 8, 32'd4, 2'b10);
    st(B + 0, 32'h07, 2'b11);
    st(B + 0, 32'hC4, 2'b01);
    check_frame(8'h07, 4);
    check_frame(8'hC4, 4);
    ld(B + 4, 3'b010, r);
    check("b2b idle", r, 32'h0000_0004);
    check("b2b txd", 32'(txd), 32'd1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
